// File: rtl/vpu_opget_unit.sv
`timescale 1ns/1ps
// VPU operand-fetch stage: issues credit-gated SRAM reads for each enabled port
// and collects the returning beats into per-port show-ahead operand queues.
module vpu_opget_unit #(
  parameter int SRAM_R_PORT_CNT = 3,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 256,
  parameter int BEATS           = 2,
  parameter int SRAM_RD_LAT     = 2,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_i,
  input  logic [SRAM_R_PORT_CNT-1:0]          rvalid_i,
  input  logic [SRAM_R_PORT_CNT*ADDR_W-1:0]   src_addr_i,
  output logic                                done_o,
  output logic                                busy_o,
  output logic [SRAM_R_PORT_CNT-1:0]          sram_rden_o,
  output logic [SRAM_R_PORT_CNT*ADDR_W-1:0]   sram_addr_o,
  input  logic [SRAM_R_PORT_CNT*DATA_W-1:0]   sram_rdata_i,
  input  logic [SRAM_R_PORT_CNT-1:0]          q_rden_i,
  output logic [SRAM_R_PORT_CNT*DATA_W-1:0]   q_rdata_o,
  output logic [SRAM_R_PORT_CNT-1:0]          q_empty_o,
  output logic                                err_o
);

  localparam int P  = SRAM_R_PORT_CNT;
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int SW = $clog2(QUEUE_DEPTH + SRAM_RD_LAT + 1);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                            state_q;
  logic [BW-1:0]                     beat_q;
  logic [P-1:0]                      mask_q;
  logic [P-1:0][ADDR_W-1:0]          base_q;
  logic [SRAM_RD_LAT-1:0][P-1:0]     vld_q;
  logic [P-1:0][PW-1:0]              wptr_q, rptr_q;
  logic [P-1:0][CW-1:0]              cnt_q;
  logic [DATA_W-1:0]                 mem_q [P][QUEUE_DEPTH];
  logic                              err_q;

  logic [P-1:0][ADDR_W-1:0]          addr;
  logic [P-1:0][DATA_W-1:0]          rdata, qdata;
  logic [P-1:0][SW-1:0]              occ;
  logic [P-1:0]                      rden, push, pop, empty;
  logic                              credit_ok, issue, pending;

  assign rdata = sram_rdata_i;

  // Occupancy counts reads still in the latency pipe so a queue can never overflow.
  always_comb begin
    credit_ok = 1'b1;
    for (int k = 0; k < P; k++) begin
      occ[k] = SW'(cnt_q[k]);
      for (int s = 0; s < SRAM_RD_LAT; s++) occ[k] = occ[k] + SW'(vld_q[s][k]);
      if (mask_q[k] && (occ[k] >= SW'(QUEUE_DEPTH))) credit_ok = 1'b0;
    end
  end

  // Reads in the last pipe stage land at this edge, so only earlier stages keep DRAIN waiting.
  always_comb begin
    pending = 1'b0;
    for (int s = 0; s < SRAM_RD_LAT - 1; s++) pending = pending | (|vld_q[s]);
  end

  assign issue = (state_q == ISSUE) && (mask_q != '0) && credit_ok;
  assign rden  = issue ? mask_q : '0;

  always_comb begin
    for (int k = 0; k < P; k++) begin
      addr[k]  = base_q[k] + ADDR_W'(beat_q);
      push[k]  = vld_q[SRAM_RD_LAT-1][k];
      empty[k] = (cnt_q[k] == '0);
      pop[k]   = q_rden_i[k] && !empty[k];
      qdata[k] = mem_q[k][rptr_q[k]];
    end
  end

  assign sram_rden_o = rden;
  assign sram_addr_o = addr;
  assign q_rdata_o   = qdata;
  assign q_empty_o   = empty;
  assign err_o       = err_q;
  assign done_o      = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      mask_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= ISSUE;
          mask_q  <= rvalid_i;
          beat_q  <= '0;
        end
        ISSUE: begin
          if (mask_q == '0) begin
            state_q <= DRAIN;
          end else if (issue) begin
            if (beat_q == BW'(BEATS - 1)) begin
              state_q <= DRAIN;
              beat_q  <= '0;
            end else begin
              beat_q  <= beat_q + BW'(1);
            end
          end
        end
        DRAIN:   if (!pending) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && start_i) base_q <= src_addr_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      vld_q[0] <= rden;
      for (int s = 1; s < SRAM_RD_LAT; s++) vld_q[s] <= vld_q[s-1];
      for (int k = 0; k < P; k++) begin
        if (push[k]) wptr_q[k] <= wptr_q[k] + PW'(1);
        if (pop[k])  rptr_q[k] <= rptr_q[k] + PW'(1);
        if (push[k] && !pop[k])      cnt_q[k] <= cnt_q[k] + CW'(1);
        else if (pop[k] && !push[k]) cnt_q[k] <= cnt_q[k] - CW'(1);
        if (q_rden_i[k] && empty[k]) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < P; k++) begin
      if (push[k]) mem_q[k][wptr_q[k]] <= rdata[k];
    end
  end

endmodule

// File: tb/tb_vpu_opget_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for vpu_opget_unit: directed fetches with hand-computed strobe
// cycles/addresses, done cycles and queue contents, checked by a negedge monitor.
module tb_vpu_opget_unit;

  localparam int P   = 3;
  localparam int AW  = 16;
  localparam int DW  = 256;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic [P-1:0]    rvalid_i = '0;
  logic [P*AW-1:0] src_addr_i = '0;
  logic            done_o, busy_o, err_o;
  logic [P-1:0]    sram_rden_o, q_empty_o;
  logic [P*AW-1:0] sram_addr_o;
  logic [P*DW-1:0] sram_rdata_i;
  logic [P-1:0]    q_rden_i = '0;
  logic [P*DW-1:0] q_rdata_o;

  vpu_opget_unit #(
    .SRAM_R_PORT_CNT(P), .ADDR_W(AW), .DATA_W(DW),
    .BEATS(2), .SRAM_RD_LAT(LAT), .QUEUE_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .rvalid_i(rvalid_i),
    .src_addr_i(src_addr_i), .done_o(done_o), .busy_o(busy_o),
    .sram_rden_o(sram_rden_o), .sram_addr_o(sram_addr_o),
    .sram_rdata_i(sram_rdata_i), .q_rden_i(q_rden_i),
    .q_rdata_o(q_rdata_o), .q_empty_o(q_empty_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] w(input int k, input logic [AW-1:0] a);
    return {224'h0, 8'(k), 8'h5A, a};
  endfunction

  // SRAM model: fixed-latency return; junk data whenever no read is due
  logic [P-1:0]    dv [LAT];
  logic [P*AW-1:0] da [LAT];
  always @(posedge clk) begin
    dv[0] <= sram_rden_o;
    da[0] <= sram_addr_o;
    for (int s = 1; s < LAT; s++) begin
      dv[s] <= dv[s-1];
      da[s] <= da[s-1];
    end
  end
  always_comb begin
    sram_rdata_i = '0;
    for (int k = 0; k < P; k++)
      sram_rdata_i[k*DW +: DW] = dv[LAT-1][k] ? w(k, da[LAT-1][k*AW +: AW]) : {8{32'hDEADBEEF}};
  end

  typedef struct packed {
    int              c;
    logic [P-1:0]    m;
    logic [P*AW-1:0] a;
  } strb_t;

  strb_t           exp_strb[$];
  int              exp_done[$];
  logic [DW-1:0]   eq0[$], eq1[$], eq2[$];
  int              checks = 0;
  int              fails = 0;
  bit              mon_en = 1'b0;

  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_strobe(input int c, input logic [P-1:0] m,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    strb_t e;
    e.c = c; e.m = m; e.a = {a2, a1, a0};
    exp_strb.push_back(e);
  endtask

  task automatic exp_data(input int k, input logic [AW-1:0] a);
    case (k)
      0: eq0.push_back(w(0, a));
      1: eq1.push_back(w(1, a));
      default: eq2.push_back(w(2, a));
    endcase
  endtask

  task automatic take(input int k, output bit have, output logic [DW-1:0] d);
    have = 1'b0; d = '0;
    case (k)
      0: if (eq0.size() != 0) begin have = 1'b1; d = eq0.pop_front(); end
      1: if (eq1.size() != 0) begin have = 1'b1; d = eq1.pop_front(); end
      default: if (eq2.size() != 0) begin have = 1'b1; d = eq2.pop_front(); end
    endcase
  endtask

  task automatic go(input logic [P-1:0] m, input logic [AW-1:0] a0,
                    input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rvalid_i = m; src_addr_i = {a2, a1, a0}; start_i = 1'b1;
    tick(1);
    start_i = 1'b0; rvalid_i = '0;
  endtask

  task automatic pop(input logic [P-1:0] m);
    q_rden_i = m;
    tick(1);
    q_rden_i = '0;
  endtask

  // Monitor: strobes, done pulses and pops are matched against the expectation queues
  initial begin
    strb_t           e;
    logic [P*AW-1:0] amask;
    bit              have;
    logic [DW-1:0]   d;
    int              dc;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sram_rden_o != '0) begin
          checks++;
          if (exp_strb.size() == 0) begin
            fails++;
            $display("FAIL strobe at cycle %0d: got mask %b, none expected", cyc, sram_rden_o);
          end else begin
            e = exp_strb.pop_front();
            amask = '0;
            for (int k = 0; k < P; k++) if (e.m[k]) amask[k*AW +: AW] = '1;
            if (cyc != e.c || sram_rden_o != e.m || (sram_addr_o & amask) != (e.a & amask)) begin
              fails++;
              $display("FAIL strobe: got cycle %0d mask %b addr %h, expected cycle %0d mask %b addr %h",
                       cyc, sram_rden_o, sram_addr_o & amask, e.c, e.m, e.a & amask);
            end
          end
        end
        if (done_o) begin
          if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            dc = exp_done.pop_front();
            chk("done_cycle", cyc, dc);
          end
        end
        for (int k = 0; k < P; k++) begin
          if (q_rden_i[k]) begin
            take(k, have, d);
            if (have) chk($sformatf("pop_data_q%0d", k), q_rdata_o[k*DW +: DW], d);
            else      chk($sformatf("pop_empty_q%0d", k), q_empty_o[k], 1);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    tick(3);
    rst = 1'b0;
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rden", sram_rden_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_empty", q_empty_o, 3'b111);
    mon_en = 1'b1;
    tick(2);

    // all ports, unstalled
    c0 = cyc;
    exp_strobe(c0 + 1, 3'b111, 16'h0010, 16'h0020, 16'h0030);
    exp_strobe(c0 + 2, 3'b111, 16'h0011, 16'h0021, 16'h0031);
    exp_done.push_back(c0 + 5);
    for (int k = 0; k < P; k++) begin
      exp_data(k, 16'h0010 + 16'(k * 16));
      exp_data(k, 16'h0011 + 16'(k * 16));
    end
    go(3'b111, 16'h0010, 16'h0020, 16'h0030);
    tick(2);
    chk("t1_empty_c3", q_empty_o, 3'b111);
    tick(1);
    chk("t1_empty_c4", q_empty_o, 3'b000);
    tick(2);
    pop(3'b111);
    pop(3'b111);
    chk("t1_drained", q_empty_o, 3'b111);

    // single port
    c0 = cyc;
    exp_strobe(c0 + 1, 3'b010, 16'h0000, 16'h0040, 16'h0000);
    exp_strobe(c0 + 2, 3'b010, 16'h0000, 16'h0041, 16'h0000);
    exp_done.push_back(c0 + 5);
    exp_data(1, 16'h0040);
    exp_data(1, 16'h0041);
    go(3'b010, 16'h0099, 16'h0040, 16'h0077);
    tick(5);
    chk("t2_empty", q_empty_o, 3'b101);
    pop(3'b010);
    pop(3'b010);

    // empty mask
    c0 = cyc;
    exp_done.push_back(c0 + 3);
    go(3'b000, 16'h0001, 16'h0002, 16'h0003);
    chk("t3_busy_c1", busy_o, 1);
    tick(1);
    chk("t3_busy_c2", busy_o, 1);
    tick(1);
    chk("t3_busy_c3", busy_o, 1);
    tick(1);
    chk("t3_busy_c4", busy_o, 0);
    tick(1);

    // prefill each queue to 3 entries
    c0 = cyc;
    exp_strobe(c0 + 1, 3'b111, 16'h0100, 16'h0200, 16'h0300);
    exp_strobe(c0 + 2, 3'b111, 16'h0101, 16'h0201, 16'h0301);
    exp_done.push_back(c0 + 5);
    for (int k = 0; k < P; k++) begin
      exp_data(k, 16'h0100 + 16'(k * 256));
      exp_data(k, 16'h0101 + 16'(k * 256));
    end
    go(3'b111, 16'h0100, 16'h0200, 16'h0300);
    tick(5);
    c0 = cyc;
    exp_strobe(c0 + 1, 3'b111, 16'h0108, 16'h0208, 16'h0308);
    exp_strobe(c0 + 2, 3'b111, 16'h0109, 16'h0209, 16'h0309);
    exp_done.push_back(c0 + 5);
    for (int k = 0; k < P; k++) begin
      exp_data(k, 16'h0108 + 16'(k * 256));
      exp_data(k, 16'h0109 + 16'(k * 256));
    end
    go(3'b111, 16'h0108, 16'h0208, 16'h0308);
    tick(5);
    pop(3'b111);

    // credit stall: beat 1 waits for the pop issued at c0+4
    c0 = cyc;
    exp_strobe(c0 + 1, 3'b111, 16'h0180, 16'h0280, 16'h0380);
    exp_strobe(c0 + 5, 3'b111, 16'h0181, 16'h0281, 16'h0381);
    exp_done.push_back(c0 + 8);
    for (int k = 0; k < P; k++) begin
      exp_data(k, 16'h0180 + 16'(k * 256));
      exp_data(k, 16'h0181 + 16'(k * 256));
    end
    go(3'b111, 16'h0180, 16'h0280, 16'h0380);
    tick(3);
    pop(3'b111);
    tick(4);
    chk("t4_busy_end", busy_o, 0);
    for (int i = 0; i < 4; i++) pop(3'b111);
    chk("t4_drained", q_empty_o, 3'b111);

    // address wrap, then pop on empty
    c0 = cyc;
    exp_strobe(c0 + 1, 3'b001, 16'hFFFF, 16'h0000, 16'h0000);
    exp_strobe(c0 + 2, 3'b001, 16'h0000, 16'h0000, 16'h0000);
    exp_done.push_back(c0 + 5);
    exp_data(0, 16'hFFFF);
    exp_data(0, 16'h0000);
    go(3'b001, 16'hFFFF, 16'h1234, 16'h5678);
    tick(5);
    pop(3'b001);
    pop(3'b001);
    chk("t5_err_before", err_o, 0);
    pop(3'b101);
    chk("t5_err_set", err_o, 1);
    tick(3);
    chk("t5_err_held", err_o, 1);

    // reset while reads are in flight
    c0 = cyc;
    exp_strobe(c0 + 1, 3'b010, 16'h0000, 16'h0600, 16'h0000);
    exp_strobe(c0 + 2, 3'b010, 16'h0000, 16'h0601, 16'h0000);
    exp_done.push_back(c0 + 5);
    exp_data(1, 16'h0600);
    exp_data(1, 16'h0601);
    go(3'b010, 16'h0000, 16'h0600, 16'h0000);
    tick(5);
    chk("t6_prefill", q_empty_o, 3'b101);
    c0 = cyc;
    exp_strobe(c0 + 1, 3'b111, 16'h0700, 16'h0800, 16'h0900);
    exp_strobe(c0 + 2, 3'b111, 16'h0701, 16'h0801, 16'h0901);
    go(3'b111, 16'h0700, 16'h0800, 16'h0900);
    tick(2);
    chk("t6_busy_drain", busy_o, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    eq0.delete(); eq1.delete(); eq2.delete();
    chk("t6_busy", busy_o, 0);
    chk("t6_empty_c4", q_empty_o, 3'b111);
    chk("t6_err_clr", err_o, 0);
    tick(1);
    chk("t6_empty_c5", q_empty_o, 3'b111);
    tick(1);
    chk("t6_empty_c6", q_empty_o, 3'b111);
    tick(4);

    chk("strobes_left", exp_strb.size(), 0);
    chk("done_left", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
